// File: rtl/mem_arbiter_pkg.sv
// Shared cache/memory definitions: bus command encoding, arbiter FSM states
// and the default starvation bound used by mem_arbiter.
package mem_arbiter_pkg;

  localparam int XLEN                 = 32;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_LOAD  = 2'b01,
    BUS_STORE = 2'b10
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT_I = 2'b01,
    WAIT_D = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: dcache has priority, icache is protected from
// starvation, and at most one memory load is in flight at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  BUS_COMMAND       icache2arb_command,
  input  logic [XLEN-1:0]  icache2arb_addr,
  output logic             arb2icache_valid,
  output logic [63:0]      arb2icache_data,
  input  BUS_COMMAND       dcache2arb_command,
  input  logic [XLEN-1:0]  dcache2arb_addr,
  input  logic [63:0]      dcache2arb_data,
  output logic             arb2dcache_valid,
  output logic [63:0]      arb2dcache_data,
  output BUS_COMMAND       arb2mem_command,
  output logic [XLEN-1:0]  arb2mem_addr,
  output logic [63:0]      arb2mem_data,
  input  logic             mem2arb_valid,
  input  logic [63:0]      mem2arb_data
);

  // One spare code point keeps the width sane even for STARVE_LIMIT == 0.
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX  = cnt_t'(STARVE_LIMIT);
  localparam cnt_t CNT_ONE  = cnt_t'(32'd1);
  localparam cnt_t CNT_ZERO = cnt_t'(32'd0);

  arb_state_t state_q, state_d;
  cnt_t       starve_cnt_q, starve_cnt_d;
  logic       i_req, d_req;
  logic       grant_i, grant_d;

  assign arb2icache_data = mem2arb_data;
  assign arb2dcache_data = mem2arb_data;

  // Request decode and IDLE-state winner selection.
  always_comb begin
    i_req   = (icache2arb_command == BUS_LOAD);
    d_req   = (dcache2arb_command == BUS_LOAD) || (dcache2arb_command == BUS_STORE);
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst && (state_q == IDLE)) begin
      if (i_req && (!d_req || (starve_cnt_q == CNT_MAX))) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end else begin
        grant_i = 1'b0;
      end
    end else begin
      grant_d = 1'b0;
    end
  end

  // Next-state, memory command mux, response routing and starvation counter.
  always_comb begin
    state_d          = state_q;
    starve_cnt_d     = starve_cnt_q;
    arb2mem_command  = BUS_NONE;
    arb2mem_addr     = {XLEN{1'b0}};
    arb2mem_data     = 64'h0;
    arb2icache_valid = 1'b0;
    arb2dcache_valid = 1'b0;
    if (rst) begin
      state_d      = IDLE;
      starve_cnt_d = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            arb2mem_command = BUS_LOAD;
            arb2mem_addr    = icache2arb_addr;
            state_d         = WAIT_I;
          end else if (grant_d) begin
            arb2mem_command = dcache2arb_command;
            arb2mem_addr    = dcache2arb_addr;
            arb2mem_data    = dcache2arb_data;
            // Stores complete on acceptance; only loads occupy the memory port.
            if (dcache2arb_command == BUS_STORE) begin
              arb2dcache_valid = 1'b1;
              state_d          = IDLE;
            end else begin
              state_d = WAIT_D;
            end
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_I: begin
          if (mem2arb_valid) begin
            arb2icache_valid = 1'b1;
            state_d          = IDLE;
          end else begin
            state_d = WAIT_I;
          end
        end
        WAIT_D: begin
          if (mem2arb_valid) begin
            arb2dcache_valid = 1'b1;
            state_d          = IDLE;
          end else begin
            state_d = WAIT_D;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (!i_req || grant_i) begin
        starve_cnt_d = CNT_ZERO;
      end else if (grant_d && (starve_cnt_q != CNT_MAX)) begin
        starve_cnt_d = starve_cnt_q + CNT_ONE;
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end
  end

  // State and starvation counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= CNT_ZERO;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized protocol-respecting traffic checked against a transaction model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic             clk = 1'b0;
  logic             rst;
  BUS_COMMAND       icmd, dcmd, mcmd;
  logic [XLEN-1:0]  iaddr, daddr, maddr;
  logic [63:0]      dwdata, idata_o, ddata_o, mdata_o, mem_rdata;
  logic             ivalid, dvalid, mem_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: who owns the outstanding load (0 none, 1 icache, 2 dcache)
  // and how many dcache grants icache has watched go by.
  int         m_owner  = 0;
  int         m_starve = 0;
  bit         e_iv, e_dv;
  BUS_COMMAND e_cmd = BUS_NONE;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk                (clk),
    .rst                (rst),
    .icache2arb_command (icmd),
    .icache2arb_addr    (iaddr),
    .arb2icache_valid   (ivalid),
    .arb2icache_data    (idata_o),
    .dcache2arb_command (dcmd),
    .dcache2arb_addr    (daddr),
    .dcache2arb_data    (dwdata),
    .arb2dcache_valid   (dvalid),
    .arb2dcache_data    (ddata_o),
    .arb2mem_command    (mcmd),
    .arb2mem_addr       (maddr),
    .arb2mem_data       (mdata_o),
    .mem2arb_valid      (mem_valid),
    .mem2arb_data       (mem_rdata)
  );

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Reference model: derive this cycle's outputs from the arbitration rules,
  // compare, then advance the model to the state after the coming edge.
  always @(negedge clk) begin : model_check
    bit              ireq, dreq;
    int              win;
    logic [XLEN-1:0] ea;
    logic [63:0]     ed;
    ireq  = (icmd == BUS_LOAD);
    dreq  = (dcmd == BUS_LOAD) || (dcmd == BUS_STORE);
    win   = 0;
    e_cmd = BUS_NONE;
    ea    = '0;
    ed    = 64'h0;
    e_iv  = 1'b0;
    e_dv  = 1'b0;
    if (!rst) begin
      if (m_owner == 0) begin
        if (ireq && (!dreq || m_starve >= LIMIT)) win = 1;
        else if (dreq) win = 2;
      end else if (mem_valid) begin
        if (m_owner == 1) e_iv = 1'b1;
        else e_dv = 1'b1;
      end
    end
    if (win == 1) begin
      e_cmd = BUS_LOAD;
      ea    = iaddr;
    end else if (win == 2) begin
      e_cmd = dcmd;
      ea    = daddr;
      ed    = dwdata;
      if (dcmd == BUS_STORE) e_dv = 1'b1;
    end
    check64("m_cmd",    64'(mcmd),    64'(e_cmd));
    check64("m_addr",   64'(maddr),   64'(ea));
    check64("m_wdata",  mdata_o,      ed);
    check64("m_ivalid", 64'(ivalid),  64'(e_iv));
    check64("m_dvalid", 64'(dvalid),  64'(e_dv));
    check64("m_idata",  idata_o,      mem_rdata);
    check64("m_ddata",  ddata_o,      mem_rdata);
    if (rst) m_owner = 0;
    else if (win == 1) m_owner = 1;
    else if (win == 2) m_owner = (dcmd == BUS_LOAD) ? 2 : 0;
    else if (m_owner != 0 && mem_valid) m_owner = 0;
    if (rst || !ireq || win == 1) m_starve = 0;
    else if (win == 2 && m_starve < LIMIT) m_starve = m_starve + 1;
  end

  initial begin : stim
    int   loads, dpulses;
    bit   i_act, d_act;
    int   delay;
    rst = 1'b1; icmd = BUS_NONE; dcmd = BUS_STORE; iaddr = '0; daddr = 32'h40;
    dwdata = 64'h77; mem_valid = 1'b0; mem_rdata = 64'h0;

    // Reset: a pending store must be neither issued nor acknowledged.
    settle();
    check64("rst_cmd",    64'(mcmd),   64'(BUS_NONE));
    check64("rst_dvalid", 64'(dvalid), 64'h0);
    check64("rst_ivalid", 64'(ivalid), 64'h0);
    step();
    rst = 1'b0; dcmd = BUS_NONE;
    check64("rst_state", 64'(dut.state_q), 64'(IDLE));

    // Lone dcache load, response three cycles after the grant.
    dcmd = BUS_LOAD; daddr = 32'h100; dwdata = 64'h0;
    loads = 0; dpulses = 0;
    for (int c = 0; c < 6; c++) begin
      mem_valid = (c == 3);
      mem_rdata = (c == 3) ? 64'hDEADBEEF_CAFEF00D : 64'h1111_2222_3333_4444;
      settle();
      if (mcmd == BUS_LOAD) loads++;
      if (dvalid) begin
        dpulses++;
        check64("s1_data", ddata_o, 64'hDEADBEEF_CAFEF00D);
      end
      if (c == 0) check64("s1_addr", 64'(maddr), 64'h100);
      step();
      if (c == 3) dcmd = BUS_NONE;
    end
    mem_valid = 1'b0;
    check64("s1_load_cycles", 64'(loads),   64'd1);
    check64("s1_pulses",      64'(dpulses), 64'd1);

    // Simultaneous icache load and dcache store: store first, load next.
    icmd = BUS_LOAD; iaddr = 32'h200;
    dcmd = BUS_STORE; daddr = 32'h300; dwdata = 64'h5555_AAAA_0123_4567;
    settle();
    check64("s2_store_cmd",  64'(mcmd),   64'(BUS_STORE));
    check64("s2_store_addr", 64'(maddr),  64'h300);
    check64("s2_store_data", mdata_o,     64'h5555_AAAA_0123_4567);
    check64("s2_store_ack",  64'(dvalid), 64'h1);
    step();
    dcmd = BUS_NONE;
    settle();
    check64("s2_iload_cmd",  64'(mcmd),  64'(BUS_LOAD));
    check64("s2_iload_addr", 64'(maddr), 64'h200);
    step();
    mem_valid = 1'b1; mem_rdata = 64'h0BAD_F00D_1234_5678;
    settle();
    check64("s2_ivalid", 64'(ivalid), 64'h1);
    check64("s2_idata",  idata_o,     64'h0BAD_F00D_1234_5678);
    step();
    icmd = BUS_NONE; mem_valid = 1'b0;

    // Starvation: four dcache loads, then icache must win the fifth grant.
    icmd = BUS_LOAD; iaddr = 32'h400;
    dcmd = BUS_LOAD; daddr = 32'h510;
    for (int g = 1; g <= 5; g++) begin
      settle();
      check64("s3_grant_cmd",  64'(mcmd),  64'(BUS_LOAD));
      check64("s3_grant_addr", 64'(maddr), (g < 5) ? 64'(32'h500 + 32'(g) * 32'h10) : 64'h400);
      step();
      mem_valid = 1'b1; mem_rdata = 64'(g);
      settle();
      if (g < 5) begin
        check64("s3_dvalid", 64'(dvalid), 64'h1);
      end else begin
        check64("s3_ivalid", 64'(ivalid), 64'h1);
        check64("s3_starve_clear", 64'(dut.starve_cnt_q), 64'h0);
      end
      step();
      mem_valid = 1'b0;
      if (g < 5) daddr = 32'h500 + 32'(g + 1) * 32'h10;
      else icmd = BUS_NONE;
    end
    settle();
    check64("s3_after_addr", 64'(maddr), 64'h550);
    step();
    mem_valid = 1'b1;
    settle();
    step();
    dcmd = BUS_NONE; mem_valid = 1'b0;

    // Spurious memory response while idle.
    mem_valid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    settle();
    check64("s4_ivalid", 64'(ivalid), 64'h0);
    check64("s4_dvalid", 64'(dvalid), 64'h0);
    step();
    mem_valid = 1'b0;
    settle();
    check64("s4_state", 64'(dut.state_q), 64'(IDLE));
    step();

    // Reset while waiting on a dcache load; late response is dropped.
    dcmd = BUS_LOAD; daddr = 32'h600;
    settle();
    check64("s5_grant", 64'(mcmd), 64'(BUS_LOAD));
    step();
    rst = 1'b1;
    settle();
    check64("s5_rst_dvalid", 64'(dvalid), 64'h0);
    step();
    rst = 1'b0; dcmd = BUS_NONE; mem_valid = 1'b1; mem_rdata = 64'h1234;
    settle();
    check64("s5_late_dvalid", 64'(dvalid), 64'h0);
    check64("s5_state", 64'(dut.state_q), 64'(IDLE));
    step();
    mem_valid = 1'b0;

    // dcache abandons its load mid-wait while icache queues behind it.
    dcmd = BUS_LOAD; daddr = 32'h700;
    settle();
    check64("s6_grant_addr", 64'(maddr), 64'h700);
    step();
    dcmd = BUS_NONE; icmd = BUS_LOAD; iaddr = 32'h800;
    settle();
    check64("s6_wait_cmd", 64'(mcmd), 64'(BUS_NONE));
    step();
    mem_valid = 1'b1; mem_rdata = 64'hABCD;
    settle();
    check64("s6_dvalid", 64'(dvalid), 64'h1);
    check64("s6_ivalid", 64'(ivalid), 64'h0);
    step();
    mem_valid = 1'b0;
    settle();
    check64("s6_icache_cmd",  64'(mcmd),  64'(BUS_LOAD));
    check64("s6_icache_addr", 64'(maddr), 64'h800);
    step();
    mem_valid = 1'b1;
    settle();
    check64("s6_ivalid_end", 64'(ivalid), 64'h1);
    step();
    icmd = BUS_NONE; mem_valid = 1'b0;

    // Randomized traffic; requesters hold until the model says they were served.
    i_act = 1'b0; d_act = 1'b0; delay = 0;
    for (int c = 0; c < 3000; c++) begin
      if (i_act && e_iv) i_act = 1'b0;
      if (d_act && e_dv) d_act = 1'b0;
      if (d_act && $urandom_range(0, 49) == 0) d_act = 1'b0;
      if (!i_act && $urandom_range(0, 9) < 3) begin
        i_act = 1'b1;
        iaddr = {$urandom} & 32'hFFFF_FFF8;
      end
      if (!d_act && $urandom_range(0, 9) < 4) begin
        d_act  = 1'b1;
        dcmd   = ($urandom_range(0, 1) == 0) ? BUS_LOAD : BUS_STORE;
        daddr  = {$urandom} & 32'hFFFF_FFF8;
        dwdata = {$urandom, $urandom};
      end
      icmd = i_act ? BUS_LOAD : BUS_NONE;
      if (!d_act) dcmd = BUS_NONE;
      if (e_cmd == BUS_LOAD) delay = $urandom_range(0, 3);
      mem_valid = 1'b0;
      if (m_owner != 0) begin
        if (delay <= 0) mem_valid = 1'b1;
        else delay--;
      end else begin
        mem_valid = ($urandom_range(0, 19) == 0);
      end
      mem_rdata = {$urandom, $urandom};
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; icmd = BUS_NONE; dcmd = BUS_NONE; mem_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
